wall_lookup_sequencer: RTL and testbench

//  Per physics tick, fetches the four maze-wall bits around the ball from the single-port maze wall memory.

---
 rtl/ball_maze_pkg.sv | 32 +++
 rtl/maze_port_arbiter.sv | 76 +++++++
 rtl/wall_lookup_sequencer.sv | 154 +++++++++++++++
 tb/tb_wall_lookup_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_maze_pkg.sv
// Shared types and helpers for the ball wall-lookup path: sequencer states,
// wall direction tags and the {row, col} maze address packing.
package ball_maze_pkg;

  localparam int ADDR_W         = 16;
  localparam int MAZE_COLS_DEF  = 256;
  localparam int MAZE_ROWS_DEF  = 192;
  localparam int STARVE_MAX_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    Q_UP,
    Q_DOWN,
    Q_LEFT,
    Q_RIGHT,
    WAIT,
    DONE
  } seq_state_t;

  // Bit position of each neighbour inside the 4-bit shadow/flag vectors.
  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } wall_dir_t;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] row, input logic [7:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/maze_port_arbiter.sv
// Shares the single maze-memory read port between the VGA renderer and the
// ball sequencer; renderer wins unless the ball has starved for STARVE_MAX cycles.
module maze_port_arbiter
  import ball_maze_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk108MHz,
  input  logic              resetPressed,
  input  logic              vgaReq,
  input  logic [ADDR_W-1:0] vgaAddr,
  input  logic              ballReq,
  input  logic [ADDR_W-1:0] ballAddr,
  input  wall_dir_t         ballDir,
  input  logic              memRdData,
  output logic              vgaGrant,
  output logic              ballIssue,
  output logic [ADDR_W-1:0] memAddr,
  output logic              vgaData,
  output logic              vgaValid,
  output logic              ballDataValid,
  output wall_dir_t         ballDataDir,
  output logic              ballData
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0]  starveCnt;
  logic              forcePort;
  logic [ADDR_W-1:0] addrHold;
  logic              tagVga;
  logic              tagBall;
  wall_dir_t         tagDir;

  assign forcePort = ballReq && (starveCnt == CNT_W'(STARVE_MAX));
  assign vgaGrant  = vgaReq && !forcePort;
  assign ballIssue = ballReq && !vgaGrant;

  // When nobody reads, the address simply holds its last value.
  always_comb begin
    memAddr = addrHold;
    if (vgaGrant) begin
      memAddr = vgaAddr;
    end else if (ballIssue) begin
      memAddr = ballAddr;
    end
  end

  always_ff @(posedge clk108MHz) begin
    if (resetPressed) begin
      starveCnt <= '0;
      addrHold  <= '0;
      tagVga    <= 1'b0;
      tagBall   <= 1'b0;
      tagDir    <= DIR_UP;
    end else begin
      addrHold <= memAddr;
      tagVga   <= vgaGrant;
      tagBall  <= ballIssue;
      tagDir   <= ballDir;
      if (ballIssue) begin
        starveCnt <= '0;
      end else if (ballReq && vgaReq) begin
        starveCnt <= starveCnt + 1'b1;
      end
    end
  end

  // Owner tags line up with the one-cycle memory latency.
  assign vgaValid      = tagVga;
  assign vgaData       = tagVga & memRdData;
  assign ballDataValid = tagBall;
  assign ballDataDir   = tagDir;
  assign ballData      = memRdData;

endmodule

// File: rtl/wall_lookup_sequencer.sv
// Per physics tick, reads the four wall bits around a snapshot of the ball
// position and presents them as registered flags with a one-cycle stepEn.
module wall_lookup_sequencer
  import ball_maze_pkg::*;
#(
  parameter int MAZE_COLS  = MAZE_COLS_DEF,
  parameter int MAZE_ROWS  = MAZE_ROWS_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk108MHz,
  input  logic              resetPressed,
  input  logic              tickIn,
  input  logic [7:0]        ballColumn,
  input  logic [7:0]        ballRow,
  input  logic              vgaReq,
  input  logic [ADDR_W-1:0] vgaAddr,
  output logic              vgaGrant,
  output logic              vgaData,
  output logic              vgaValid,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memRdData,
  output logic              wallAboveball,
  output logic              wallBelowball,
  output logic              wallLeftOfball,
  output logic              wallRightOfball,
  output logic              stepEn,
  output logic              busy,
  output logic              tickOverrun
);

  localparam logic [7:0] LAST_ROW = 8'(MAZE_ROWS - 1);
  localparam logic [7:0] LAST_COL = 8'(MAZE_COLS - 1);

  seq_state_t        stateReg, stateNext;
  logic [7:0]        snapRow, snapCol;
  logic [3:0]        shadowReg, shadowNext;
  logic [3:0]        wallFlagsReg;
  logic              overrunReg;
  logic              isQuery, atEdge, ballReq, ballIssue;
  logic              ballDataValid, ballData;
  wall_dir_t         queryDir, ballDataDir;
  logic [ADDR_W-1:0] ballAddr;

  maze_port_arbiter #(.STARVE_MAX(STARVE_MAX)) arbiter (
    .clk108MHz    (clk108MHz),
    .resetPressed (resetPressed),
    .vgaReq       (vgaReq),
    .vgaAddr      (vgaAddr),
    .ballReq      (ballReq),
    .ballAddr     (ballAddr),
    .ballDir      (queryDir),
    .memRdData    (memRdData),
    .vgaGrant     (vgaGrant),
    .ballIssue    (ballIssue),
    .memAddr      (memAddr),
    .vgaData      (vgaData),
    .vgaValid     (vgaValid),
    .ballDataValid(ballDataValid),
    .ballDataDir  (ballDataDir),
    .ballData     (ballData)
  );

  // Neighbour address is only requested off the edge, so the +/-1 never wraps onto the port.
  always_comb begin
    isQuery  = 1'b1;
    atEdge   = 1'b0;
    queryDir = DIR_UP;
    ballAddr = cell_addr(snapRow, snapCol);
    case (stateReg)
      Q_UP: begin
        atEdge   = (snapRow == 8'd0);
        ballAddr = cell_addr(snapRow - 8'd1, snapCol);
      end
      Q_DOWN: begin
        queryDir = DIR_DOWN;
        atEdge   = (snapRow == LAST_ROW);
        ballAddr = cell_addr(snapRow + 8'd1, snapCol);
      end
      Q_LEFT: begin
        queryDir = DIR_LEFT;
        atEdge   = (snapCol == 8'd0);
        ballAddr = cell_addr(snapRow, snapCol - 8'd1);
      end
      Q_RIGHT: begin
        queryDir = DIR_RIGHT;
        atEdge   = (snapCol == LAST_COL);
        ballAddr = cell_addr(snapRow, snapCol + 8'd1);
      end
      default: isQuery = 1'b0;
    endcase
    ballReq = isQuery && !atEdge;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (tickIn) stateNext = Q_UP;
      Q_UP:    if (atEdge || ballIssue) stateNext = Q_DOWN;
      Q_DOWN:  if (atEdge || ballIssue) stateNext = Q_LEFT;
      Q_LEFT:  if (atEdge || ballIssue) stateNext = Q_RIGHT;
      Q_RIGHT: if (atEdge || ballIssue) stateNext = WAIT;
      WAIT:    stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    shadowNext = shadowReg;
    if (stateReg == IDLE && tickIn) begin
      shadowNext = '0;
    end
    if (ballDataValid) begin
      shadowNext[ballDataDir] = ballData;
    end
    if (isQuery && atEdge) begin
      shadowNext[queryDir] = 1'b1;
    end
  end

  always_ff @(posedge clk108MHz) begin
    if (resetPressed) begin
      stateReg     <= IDLE;
      snapRow      <= '0;
      snapCol      <= '0;
      shadowReg    <= '0;
      wallFlagsReg <= '0;
      overrunReg   <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      shadowReg <= shadowNext;
      if (stateReg == IDLE && tickIn) begin
        snapRow <= ballRow;
        snapCol <= ballColumn;
      end
      // Loaded on the WAIT->DONE edge (including the final read) so flags are fresh during DONE.
      if (stateReg == WAIT) begin
        wallFlagsReg <= shadowNext;
      end
      if (stateReg != IDLE && tickIn) begin
        overrunReg <= 1'b1;
      end
    end
  end

  assign wallAboveball   = wallFlagsReg[DIR_UP];
  assign wallBelowball   = wallFlagsReg[DIR_DOWN];
  assign wallLeftOfball  = wallFlagsReg[DIR_LEFT];
  assign wallRightOfball = wallFlagsReg[DIR_RIGHT];
  assign stepEn          = (stateReg == DONE);
  assign busy            = (stateReg != IDLE);
  assign tickOverrun     = overrunReg;

endmodule

// File: tb/tb_wall_lookup_sequencer.sv
// Scoreboard bench for wall_lookup_sequencer: drivers push expected stepEn and
// vgaValid responses, a negedge monitor pops and compares them.
module tb_wall_lookup_sequencer;
  import ball_maze_pkg::*;

  logic        clk108MHz = 1'b0;
  logic        resetPressed, tickIn, vgaReq, memRdData;
  logic [7:0]  ballColumn, ballRow;
  logic [15:0] vgaAddr, memAddr;
  logic        vgaGrant, vgaData, vgaValid;
  logic        wallAboveball, wallBelowball, wallLeftOfball, wallRightOfball;
  logic        stepEn, busy, tickOverrun;

  typedef struct {logic [3:0] flags; int cyc;} step_exp_t;
  typedef struct {logic data; int cyc;} vga_exp_t;

  step_exp_t stepQ[$];
  vga_exp_t  vgaQ[$];
  step_exp_t se;
  vga_exp_t  ve;
  bit        wallMem [0:65535];
  int        cyc = 0;
  int        checks = 0;
  int        failures = 0;

  always #5 clk108MHz = ~clk108MHz;

  wall_lookup_sequencer dut (
    .clk108MHz      (clk108MHz),
    .resetPressed   (resetPressed),
    .tickIn         (tickIn),
    .ballColumn     (ballColumn),
    .ballRow        (ballRow),
    .vgaReq         (vgaReq),
    .vgaAddr        (vgaAddr),
    .vgaGrant       (vgaGrant),
    .vgaData        (vgaData),
    .vgaValid       (vgaValid),
    .memAddr        (memAddr),
    .memRdData      (memRdData),
    .wallAboveball  (wallAboveball),
    .wallBelowball  (wallBelowball),
    .wallLeftOfball (wallLeftOfball),
    .wallRightOfball(wallRightOfball),
    .stepEn         (stepEn),
    .busy           (busy),
    .tickOverrun    (tickOverrun)
  );

  always @(posedge clk108MHz) cyc <= cyc + 1;
  always @(posedge clk108MHz) memRdData <= wallMem[memAddr];

  function automatic logic [3:0] fl(input logic a, input logic b, input logic l, input logic r);
    return {a, b, l, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk108MHz) begin
    if (stepEn) begin
      if (stepQ.size() == 0) begin
        check("stepEn_unexpected", 32'd1, 32'd0);
      end else begin
        se = stepQ.pop_front();
        $display("step  cyc=%0d flags(a,b,l,r)=%b", cyc,
                 fl(wallAboveball, wallBelowball, wallLeftOfball, wallRightOfball));
        check("step_flags", 32'(fl(wallAboveball, wallBelowball, wallLeftOfball, wallRightOfball)),
              32'(se.flags));
        check("step_cycle", cyc, se.cyc);
      end
    end
    if (vgaValid) begin
      if (vgaQ.size() == 0) begin
        check("vgaValid_unexpected", 32'd1, 32'd0);
      end else begin
        ve = vgaQ.pop_front();
        $display("vga   cyc=%0d data=%0b", cyc, vgaData);
        check("vga_data", 32'(vgaData), 32'(ve.data));
        check("vga_cycle", cyc, ve.cyc);
      end
    end
  end

  task automatic step(input logic tick, input logic vReq, input logic [15:0] vAddr,
                      input logic expGrant, output int c);
    @(posedge clk108MHz);
    #1;
    tickIn  = tick;
    vgaReq  = vReq;
    vgaAddr = vAddr;
    c       = cyc;
    if (vReq && expGrant) vgaQ.push_back('{wallMem[vAddr], cyc + 1});
  endtask

  task automatic idle(input int n);
    int c;
    repeat (n) step(1'b0, 1'b0, 16'h0, 1'b0, c);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((stepQ.size() != 0 || vgaQ.size() != 0) && n < 60) begin
      idle(1);
      n++;
    end
    check(name, 32'(stepQ.size() + vgaQ.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, c, changes, wraps, lows;
    logic [15:0] prev;
    logic [15:0] addrTab [3];
    logic expG;

    wallMem[cell_addr(8'd79, 8'd100)]  = 1'b1;
    wallMem[cell_addr(8'd51, 8'd60)]   = 1'b1;
    wallMem[cell_addr(8'd50, 8'd59)]   = 1'b1;
    wallMem[cell_addr(8'd99, 8'd100)]  = 1'b1;
    wallMem[cell_addr(8'd100, 8'd101)] = 1'b1;
    wallMem[cell_addr(8'd190, 8'd255)] = 1'b1;
    wallMem[cell_addr(8'd20, 8'd31)]   = 1'b1;

    resetPressed = 1'b1;
    tickIn = 1'b0; vgaReq = 1'b0; vgaAddr = '0;
    ballRow = '0; ballColumn = '0;
    repeat (3) @(posedge clk108MHz);
    #1;
    resetPressed = 1'b0;
    check("reset_flags", 32'(fl(wallAboveball, wallBelowball, wallLeftOfball, wallRightOfball)), 32'd0);
    check("reset_stepEn", 32'(stepEn), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_vgaValid", 32'(vgaValid), 32'd0);
    check("reset_overrun", 32'(tickOverrun), 32'd0);

    // 1: interior cell, wall only above
    ballRow = 8'd80; ballColumn = 8'd100;
    step(1'b1, 1'b0, 16'h0, 1'b0, t);
    stepQ.push_back('{fl(1, 0, 0, 0), t + 6});
    idle(10);
    drain("t1_drain");

    // 2: top-left corner, only DOWN and RIGHT go to memory
    ballRow = 8'd0; ballColumn = 8'd0;
    step(1'b1, 1'b0, 16'h0, 1'b0, t);
    stepQ.push_back('{fl(1, 0, 1, 0), t + 6});
    #1;
    prev = memAddr; changes = 0; wraps = 0;
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0, c);
      #1;
      if (memAddr !== prev) changes++;
      if (memAddr == 16'hFF00 || memAddr == 16'h00FF) wraps++;
      prev = memAddr;
    end
    check("t2_mem_reads", changes, 32'd2);
    check("t2_no_wrap_addr", wraps, 32'd0);
    idle(4);
    drain("t2_drain");

    // 3: renderer holds the port; ball forces through at r = 9, 18, 27, 36
    addrTab[0] = cell_addr(8'd99, 8'd100);
    addrTab[1] = cell_addr(8'd5, 8'd5);
    addrTab[2] = cell_addr(8'd100, 8'd101);
    ballRow = 8'd100; ballColumn = 8'd100;
    lows = 0; t = 0;
    for (int k = 0; k < 45; k++) begin
      expG = !(k == 10 || k == 19 || k == 28 || k == 37);
      step(k == 1, 1'b1, addrTab[k % 3], expG, c);
      if (k == 1) begin
        t = c;
        stepQ.push_back('{fl(1, 0, 0, 1), t + 38});
      end
      #1;
      if (!vgaGrant) lows++;
    end
    idle(3);
    check("t3_grant_low_count", lows, 32'd4);
    drain("t3_drain");

    // 4: renderer on alternate cycles; ball fills the gaps
    addrTab[0] = cell_addr(8'd79, 8'd100);
    addrTab[1] = cell_addr(8'd2, 8'd2);
    addrTab[2] = cell_addr(8'd51, 8'd60);
    ballRow = 8'd50; ballColumn = 8'd60;
    for (int k = 0; k < 16; k++) begin
      step(k == 0, (k % 2) == 0, addrTab[(k / 2) % 3], 1'b1, c);
      if (k == 0) stepQ.push_back('{fl(0, 1, 1, 0), c + 9});
    end
    idle(3);
    drain("t4_drain");

    // 5: second tick three cycles in is dropped and flagged
    check("t5_overrun_before", 32'(tickOverrun), 32'd0);
    ballRow = 8'd191; ballColumn = 8'd255;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) ballRow = 8'd5;
      step(k == 0 || k == 3, 1'b0, 16'h0, 1'b0, c);
      if (k == 0) stepQ.push_back('{fl(1, 1, 0, 1), c + 6});
      if (k == 5) begin
        #1;
        check("t5_overrun_set", 32'(tickOverrun), 32'd1);
      end
    end
    check("t5_overrun_sticky", 32'(tickOverrun), 32'd1);
    drain("t5_drain");

    // 6: reset mid-sequence aborts; a later tick runs clean
    ballRow = 8'd20; ballColumn = 8'd20;
    for (int k = 0; k < 5; k++) begin
      step(k == 0, 1'b0, 16'h0, 1'b0, c);
      resetPressed = (k == 3);
    end
    #1;
    check("t6_flags_cleared", 32'(fl(wallAboveball, wallBelowball, wallLeftOfball, wallRightOfball)), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_stepEn", 32'(stepEn), 32'd0);
    check("t6_overrun_cleared", 32'(tickOverrun), 32'd0);
    idle(8);
    ballRow = 8'd20; ballColumn = 8'd30;
    step(1'b1, 1'b0, 16'h0, 1'b0, t);
    stepQ.push_back('{fl(0, 0, 0, 1), t + 6});
    idle(10);
    check("t6_overrun_clean", 32'(tickOverrun), 32'd0);
    drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
